// File: rtl/lcd_nibble_tx.sv
// HD44780 4-bit bus transmitter.
// Accepts one byte-wide command/character write per valid/ready handshake and
// emits it as one or two timed en strobes on the LCD pins. After the strobes
// it waits out the LCD execution time and then pulses done.
// Clocked from the 1 kHz tick, so every count below is in milliseconds.

// Parameter sanity checker: zero-length pulses or delays cannot be expressed
// by the down-counter, and neither can values that do not fit in 8 bits.
module lcd_nibble_tx_chk #(
  parameter int unsigned EN_CYCLES   = 1,
  parameter int unsigned SHORT_DELAY = 1,
  parameter int unsigned LONG_DELAY  = 2
) (
  input logic clk
);

  // Flag illegal parameter values on every clock edge.
  always @(posedge clk) begin
    assert (EN_CYCLES >= 32'd1 && EN_CYCLES <= 32'd255)
      else $error("lcd_nibble_tx: EN_CYCLES out of range 1..255");
    assert (SHORT_DELAY >= 32'd1 && SHORT_DELAY <= 32'd255)
      else $error("lcd_nibble_tx: SHORT_DELAY out of range 1..255");
    assert (LONG_DELAY >= 32'd1 && LONG_DELAY <= 32'd255)
      else $error("lcd_nibble_tx: LONG_DELAY out of range 1..255");
  end

endmodule

module lcd_nibble_tx #(
  parameter int unsigned EN_CYCLES   = 1,
  parameter int unsigned SHORT_DELAY = 1,
  parameter int unsigned LONG_DELAY  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_rs,
  input  logic       in_nib_only,
  output logic       done,
  output logic       en,
  output logic       rs,
  output logic [3:0] data
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP_H = 3'd1,
    PULSE_H = 3'd2,
    HOLD_H  = 3'd3,
    SETUP_L = 3'd4,
    PULSE_L = 3'd5,
    HOLD_L  = 3'd6,
    WAIT    = 3'd7
  } state_t;

  // Counter reload values: a count of N cycles is loaded as N-1.
  localparam logic [7:0] EN_M1    = 8'(EN_CYCLES - 32'd1);
  localparam logic [7:0] SHORT_M1 = 8'(SHORT_DELAY - 32'd1);
  localparam logic [7:0] LONG_M1  = 8'(LONG_DELAY - 32'd1);

  state_t     state_r, state_nx_s;
  logic [7:0] cnt_r, cnt_nx_s;
  logic [7:0] byte_r;
  logic       rs_lat_r;
  logic       nib_r;
  logic       accept_s;
  logic       long_sel_s;
  logic [7:0] delay_m1_s;
  logic       en_nx_s, rs_nx_s, done_nx_s, ready_nx_s;
  logic [3:0] data_nx_s;

  lcd_nibble_tx_chk #(
    .EN_CYCLES  (EN_CYCLES),
    .SHORT_DELAY(SHORT_DELAY),
    .LONG_DELAY (LONG_DELAY)
  ) u_chk (
    .clk(clk)
  );

  assign accept_s   = in_valid && in_ready;
  // Only clear and home need the long execution time; character 0x01 does not.
  assign long_sel_s = !rs_lat_r && !nib_r && (byte_r == 8'h01 || byte_r == 8'h02);
  assign delay_m1_s = long_sel_s ? LONG_M1 : SHORT_M1;

  // State and counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Latch the request on accept so the input bus is free while busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_r   <= 8'd0;
      rs_lat_r <= 1'b0;
      nib_r    <= 1'b0;
    end else if (accept_s) begin
      byte_r   <= in_data;
      rs_lat_r <= in_rs;
      nib_r    <= in_nib_only;
    end else begin
      byte_r   <= byte_r;
      rs_lat_r <= rs_lat_r;
      nib_r    <= nib_r;
    end
  end

  // Next state plus the pin values for the state being entered.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    en_nx_s    = 1'b0;
    rs_nx_s    = rs;
    data_nx_s  = data;
    done_nx_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nx_s = SETUP_H;
          rs_nx_s    = in_rs;
          data_nx_s  = in_data[7:4];
        end else begin
          state_nx_s = IDLE;
        end
      end
      SETUP_H: begin
        state_nx_s = PULSE_H;
        cnt_nx_s   = EN_M1;
        en_nx_s    = 1'b1;
      end
      PULSE_H: begin
        if (cnt_r == 8'd0) begin
          state_nx_s = HOLD_H;
        end else begin
          cnt_nx_s = cnt_r - 8'd1;
          en_nx_s  = 1'b1;
        end
      end
      HOLD_H: begin
        if (nib_r) begin
          state_nx_s = WAIT;
          cnt_nx_s   = delay_m1_s;
          done_nx_s  = (delay_m1_s == 8'd0);
        end else begin
          state_nx_s = SETUP_L;
          data_nx_s  = byte_r[3:0];
        end
      end
      SETUP_L: begin
        state_nx_s = PULSE_L;
        cnt_nx_s   = EN_M1;
        en_nx_s    = 1'b1;
      end
      PULSE_L: begin
        if (cnt_r == 8'd0) begin
          state_nx_s = HOLD_L;
        end else begin
          cnt_nx_s = cnt_r - 8'd1;
          en_nx_s  = 1'b1;
        end
      end
      HOLD_L: begin
        state_nx_s = WAIT;
        cnt_nx_s   = delay_m1_s;
        done_nx_s  = (delay_m1_s == 8'd0);
      end
      WAIT: begin
        if (cnt_r == 8'd0) begin
          state_nx_s = IDLE;
        end else begin
          cnt_nx_s  = cnt_r - 8'd1;
          done_nx_s = (cnt_r == 8'd1);
        end
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = 8'd0;
      end
    endcase
    ready_nx_s = (state_nx_s == IDLE);
  end

  // Registered pin and handshake outputs, aligned with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en       <= 1'b0;
      rs       <= 1'b0;
      data     <= 4'd0;
      done     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      en       <= en_nx_s;
      rs       <= rs_nx_s;
      data     <= data_nx_s;
      done     <= done_nx_s;
      in_ready <= ready_nx_s;
    end
  end

endmodule

// File: tb/tb_lcd_nibble_tx.sv
// Bench for lcd_nibble_tx: directed scenarios plus randomized writes, each
// compared cycle by cycle against an expected pin trace expanded from the
// write's byte, rs, nibble-only flag and strobe/delay lengths.
module tb_lcd_nibble_tx;

  localparam int SHORT = 1;
  localparam int LONG  = 2;

  logic clk = 1'b0;
  logic reset;

  // Instance A: default timing.
  logic       a_valid, a_rs_in, a_nib, a_ready, a_done, a_en, a_rs;
  logic [7:0] a_din;
  logic [3:0] a_data;
  // Instance B: three-cycle enable strobes.
  logic       b_valid, b_rs_in, b_nib, b_ready, b_done, b_en, b_rs;
  logic [7:0] b_din;
  logic [3:0] b_data;

  lcd_nibble_tx dut_a (
    .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(a_ready),
    .in_data(a_din), .in_rs(a_rs_in), .in_nib_only(a_nib), .done(a_done),
    .en(a_en), .rs(a_rs), .data(a_data)
  );

  lcd_nibble_tx #(.EN_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_ready),
    .in_data(b_din), .in_rs(b_rs_in), .in_nib_only(b_nib), .done(b_done),
    .en(b_en), .rs(b_rs), .data(b_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Which instance the stimulus tasks talk to.
  int sel = 0;
  logic       o_en, o_rs, o_done, o_ready;
  logic [3:0] o_data;
  always_comb begin
    if (sel == 0) begin
      o_en = a_en; o_rs = a_rs; o_data = a_data; o_done = a_done; o_ready = a_ready;
    end else begin
      o_en = b_en; o_rs = b_rs; o_data = b_data; o_done = b_done; o_ready = b_ready;
    end
  end

  int checks = 0;
  int errors = 0;

  // Pin values the LCD last saw, per instance (held while idle).
  logic       m_rs[2];
  logic [3:0] m_data[2];

  int rises, dones, first_acc, last_done, busy_sum;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic n);
    if (sel == 0) begin
      a_valid = v; a_din = d; a_rs_in = r; a_nib = n;
    end else begin
      b_valid = v; b_din = d; b_rs_in = r; b_nib = n;
    end
  endtask

  // One write: wait for idle, hand it over, then compare every busy cycle
  // against the expected {en,rs,data,done} trace with in_ready low.
  task automatic run_write(input logic [7:0] b, input logic r, input logic nb,
                           input int ecyc, input logic keep);
    logic [6:0] q[$];
    int         d, w, done_at, exp_len;
    logic       pe;
    logic [3:0] last;
    d = (!r && !nb && (b == 8'h01 || b == 8'h02)) ? LONG : SHORT;
    q.push_back({1'b0, r, b[7:4], 1'b0});
    repeat (ecyc) q.push_back({1'b1, r, b[7:4], 1'b0});
    q.push_back({1'b0, r, b[7:4], 1'b0});
    last = b[7:4];
    if (!nb) begin
      q.push_back({1'b0, r, b[3:0], 1'b0});
      repeat (ecyc) q.push_back({1'b1, r, b[3:0], 1'b0});
      q.push_back({1'b0, r, b[3:0], 1'b0});
      last = b[3:0];
    end
    repeat (d - 1) q.push_back({1'b0, r, last, 1'b0});
    q.push_back({1'b0, r, last, 1'b1});
    exp_len = nb ? (3 + (ecyc - 1) + d) : (6 + 2 * (ecyc - 1) + d);

    w = 0;
    while (!o_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("idle_wait", 16'(w < 40), 16'd1);
    if (w >= 40) return;
    check($sformatf("idle_pins_%02h", b), {o_en, o_rs, o_data},
          {1'b0, m_rs[sel], m_data[sel]});
    drive(1'b1, b, r, nb);
    if (first_acc < 0) first_acc = cyc;
    pe = o_en;
    done_at = -1;
    for (int k = 1; k <= q.size(); k++) begin
      @(negedge clk);
      check($sformatf("trace_%02h_rs%0d_n%0d_c%0d", b, r, nb, k),
            {o_en, o_rs, o_data, o_done, o_ready}, {q[k-1], 1'b0});
      if (o_en && !pe) rises++;
      pe = o_en;
      if (o_done) begin
        dones++;
        last_done = cyc;
        if (done_at < 0) done_at = k;
      end
      if (k < q.size()) drive(1'($urandom_range(0, 1)), 8'($urandom),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else drive(keep, 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    check($sformatf("done_cycle_%02h", b), 16'(done_at), 16'(exp_len));
    busy_sum += q.size();
    m_rs[sel]   = r;
    m_data[sel] = last;
    if (!keep) begin
      @(negedge clk);
      check($sformatf("post_idle_%02h", b), {o_en, o_done, o_ready, o_rs, o_data},
            {1'b0, 1'b0, 1'b1, r, last});
    end
  endtask

  initial begin
    logic [7:0] rb;
    logic       rr, rn, rk;
    reset = 1'b0;
    a_valid = 1'b0; a_din = 8'd0; a_rs_in = 1'b0; a_nib = 1'b0;
    b_valid = 1'b0; b_din = 8'd0; b_rs_in = 1'b0; b_nib = 1'b0;
    m_rs[0] = 1'b0; m_rs[1] = 1'b0; m_data[0] = 4'd0; m_data[1] = 4'd0;
    rises = 0; dones = 0; first_acc = -1; last_done = 0; busy_sum = 0;

    // Reset state of both instances.
    #12;
    check("reset_a", {a_en, a_rs, a_data, a_done, a_ready}, 8'b0000_0001);
    check("reset_b", {b_en, b_rs, b_data, b_done, b_ready}, 8'b0000_0001);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Directed writes on the default instance.
    sel = 0;
    run_write(8'h48, 1'b1, 1'b0, 1, 1'b0);
    run_write(8'h01, 1'b0, 1'b0, 1, 1'b0);
    run_write(8'h01, 1'b1, 1'b0, 1, 1'b0);
    run_write(8'h02, 1'b0, 1'b0, 1, 1'b0);
    run_write(8'h30, 1'b0, 1'b1, 1, 1'b0);
    run_write(8'h01, 1'b0, 1'b1, 1, 1'b0);

    // Back-to-back init sequence with in_valid held high.
    rises = 0; dones = 0; first_acc = -1; busy_sum = 0;
    run_write(8'h28, 1'b0, 1'b0, 1, 1'b1);
    run_write(8'h0C, 1'b0, 1'b0, 1, 1'b1);
    run_write(8'h06, 1'b0, 1'b0, 1, 1'b1);
    run_write(8'h01, 1'b0, 1'b0, 1, 1'b0);
    check("b2b_dones", 16'(dones), 16'd4);
    check("b2b_en_rises", 16'(rises), 16'd8);
    // One idle cycle separates each done from the next accept.
    check("b2b_span", 16'(last_done - first_acc), 16'(busy_sum + 3));

    // Randomized writes, biased toward the long-delay commands.
    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom);
      if ($urandom_range(0, 3) == 0) rb = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'h02;
      rr = 1'($urandom_range(0, 1));
      rn = ($urandom_range(0, 3) == 0);
      rk = (i != 11) && ($urandom_range(0, 1) == 1);
      run_write(rb, rr, rn, 1, rk);
    end

    // Three-cycle enable strobes.
    sel = 1;
    @(negedge clk);
    run_write(8'hA5, 1'b1, 1'b0, 3, 1'b0);
    run_write(8'h01, 1'b0, 1'b0, 3, 1'b0);
    run_write(8'h20, 1'b0, 1'b1, 3, 1'b0);

    // Asynchronous reset in the middle of the low-nibble strobe.
    sel = 0;
    @(negedge clk);
    drive(1'b1, 8'h45, 1'b0, 1'b0);
    @(posedge clk);
    #1 drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    check("pre_reset_en", {a_en, a_data}, {1'b1, 4'h5});
    reset = 1'b0;
    #1;
    check("async_reset", {a_en, a_rs, a_data, a_done, a_ready}, 8'b0000_0001);
    @(negedge clk);
    reset = 1'b1;
    m_rs[0] = 1'b0; m_rs[1] = 1'b0; m_data[0] = 4'd0; m_data[1] = 4'd0;
    run_write(8'h33, 1'b0, 1'b0, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
